// File: rtl/seg_char_reader.sv
// Recovers 3-bit character codes from a sampled 7-segment bus. A pattern must be held stable
// for STABLE_CYCLES enabled samples before it is decoded and offered on a valid/ready output.
module seg_char_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       seg_en,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       err,
    output logic [7:0] err_count,
    output logic       ovr,
    input  logic       clr
);

    localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StLocked
    } state_e;

    // Returns {is_valid_char, code}.
    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        logic [3:0] res;
        case (pat)
            7'b1110111: res = {1'b1, 3'd0};
            7'b1100010: res = {1'b1, 3'd1};
            7'b0111001: res = {1'b1, 3'd2};
            7'b1011110: res = {1'b1, 3'd3};
            7'b0111111: res = {1'b1, 3'd4};
            7'b1110001: res = {1'b1, 3'd5};
            7'b1100100: res = {1'b1, 3'd6};
            7'b1110110: res = {1'b1, 3'd7};
            default:    res = {1'b0, 3'd0};
        endcase
        return res;
    endfunction

    // Input stage and qualification FSM
    state_e     state_q, state_d;
    logic [6:0] seg_q, seg_d;
    logic [7:0] cnt_q, cnt_d;
    logic       qual_q, qual_d;
    logic [6:0] qual_pat_q, qual_pat_d;

    // Output stage
    logic [2:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       ovr_q, ovr_d;

    logic       same;
    logic [3:0] decoded;
    logic       load_req;
    logic       bad_req;
    logic       consume;

    always_comb begin
        seg_d      = seg_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        qual_d     = 1'b0;
        qual_pat_d = qual_pat_q;
        same       = (seg_in == seg_q);

        if (seg_en) begin
            seg_d = seg_in;
            if (!same) begin
                cnt_d = 8'd1;
            end else if (cnt_q < StableMax) begin
                cnt_d = cnt_q + 8'd1;
            end

            if (seg_in == 7'd0) begin
                state_d = StIdle;
            end else if (state_q == StLocked && same) begin
                state_d = StLocked;
            end else if (cnt_d == StableMax) begin
                // Qualify exactly once; decoding happens on the following edge.
                state_d    = StLocked;
                qual_d     = 1'b1;
                qual_pat_d = seg_in;
            end else begin
                state_d = StQual;
            end
        end
    end

    always_comb begin
        decoded  = decode_seg(qual_pat_q);
        load_req = qual_q & decoded[3];
        bad_req  = qual_q & ~decoded[3];
        consume  = valid_q & code_ready;

        code_d    = code_q;
        valid_d   = valid_q & ~consume;
        err_d     = bad_req;
        err_cnt_d = err_cnt_q;
        ovr_d     = ovr_q;

        if (load_req && (!valid_q || consume)) begin
            code_d  = decoded[2:0];
            valid_d = 1'b1;
        end

        if (clr) begin
            err_cnt_d = 8'd0;
            ovr_d     = 1'b0;
        end else begin
            if (bad_req && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (load_req && valid_q && !consume) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            seg_q      <= 7'd0;
            cnt_q      <= 8'd0;
            qual_q     <= 1'b0;
            qual_pat_q <= 7'd0;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg_d;
            cnt_q      <= cnt_d;
            qual_q     <= qual_d;
            qual_pat_q <= qual_pat_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            ovr_q      <= ovr_d;
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign err        = err_q;
    assign err_count  = err_cnt_q;
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_seg_char_reader.sv
// Directed bench for seg_char_reader: a sample-history model predicts every output each cycle,
// and hand-computed literal checks pin the key latencies and counts.
module tb_seg_char_reader;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'd0;
    logic       seg_en = 1'b0;
    logic       code_ready = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] code_out;
    logic       code_valid;
    logic       err;
    logic [7:0] err_count;
    logic       ovr;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] pats [8] = '{7'b1110111, 7'b1100010, 7'b0111001, 7'b1011110,
                             7'b0111111, 7'b1110001, 7'b1100100, 7'b1110110};

    seg_char_reader #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .seg_en     (seg_en),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err        (err),
        .err_count  (err_count),
        .ovr        (ovr),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history of enabled samples, one-shot report per stable run, one-deep output slot.
    logic [6:0] m_last = 7'd0;
    int         m_run = 0;
    bit         m_rep = 1'b0;
    bit         m_qpend = 1'b0;
    logic [6:0] m_qpat = 7'd0;
    logic [2:0] m_code = 3'd0;
    bit         m_valid = 1'b0;
    bit         m_err = 1'b0;
    int         m_cnt = 0;
    bit         m_ovr = 1'b0;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 8; i++) if (pats[i] == p) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_last = 7'd0; m_run = 0; m_rep = 1'b0; m_qpend = 1'b0; m_qpat = 7'd0;
            m_code = 3'd0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0; m_ovr = 1'b0;
        end else begin
            bit   consume, new_valid, ovr_set, err_ev;
            logic [2:0] new_code;
            int   idx;
            consume   = m_valid && code_ready;
            new_valid = m_valid && !consume;
            new_code  = m_code;
            ovr_set   = 1'b0;
            err_ev    = 1'b0;
            if (m_qpend) begin
                idx = lookup(m_qpat);
                if (idx >= 0) begin
                    if (!m_valid || consume) begin
                        new_code  = idx[2:0];
                        new_valid = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end else begin
                    err_ev = 1'b1;
                end
            end
            m_err = err_ev;
            if (clr) begin
                m_cnt = 0;
                m_ovr = 1'b0;
            end else begin
                if (err_ev && m_cnt < 255) m_cnt++;
                if (ovr_set) m_ovr = 1'b1;
            end
            m_valid = new_valid;
            m_code  = new_code;

            m_qpend = 1'b0;
            if (seg_en) begin
                if (seg_in == m_last) m_run++;
                else begin
                    m_run = 1;
                    m_rep = 1'b0;
                end
                m_last = seg_in;
                if (seg_in != 7'd0 && !m_rep && m_run >= int'(S)) begin
                    m_rep   = 1'b1;
                    m_qpend = 1'b1;
                    m_qpat  = seg_in;
                end
            end
        end
    end

    // Inputs change at posedge+1, so at negedge they are what the next edge will sample.
    logic [2:0] xfer_log [$];
    always @(negedge clk) begin
        chk("code_out", code_out, m_code);
        chk("code_valid", code_valid, m_valid);
        chk("err", err, m_err);
        chk("err_count", err_count, m_cnt);
        chk("ovr", ovr, m_ovr);
        if (rst_n && code_valid && code_ready) xfer_log.push_back(code_out);
    end

    task automatic step(input logic [6:0] s, input logic e, input logic r, input logic c);
        @(posedge clk);
        #1;
        seg_in = s;
        seg_en = e;
        code_ready = r;
        clr = c;
    endtask

    task automatic hold(input logic [6:0] s, input logic e, input logic r, input logic c,
                        input int n);
        for (int i = 0; i < n; i++) step(s, e, r, c);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_code_valid", code_valid, 0);
        chk("rst_code_out", code_out, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_ovr", ovr, 0);

        // Basic qualify, handshake, no repeat report
        hold(7'b1011110, 1, 0, 0, 5);
        chk("t1_not_yet", code_valid, 0);
        step(7'b1011110, 1, 0, 0);
        chk("t1_valid", code_valid, 1);
        chk("t1_code", code_out, 3);
        step(7'b1011110, 1, 1, 0);
        step(7'b1011110, 1, 0, 0);
        chk("t1_consumed", code_valid, 0);
        hold(7'b1011110, 1, 0, 0, 20);
        chk("t1_no_repeat", code_valid, 0);

        // Walk all characters
        xfer_log.delete();
        for (int i = 0; i < 8; i++) begin
            hold(pats[i], 1, 1, 0, 5);
            hold(7'd0, 1, 1, 0, 3);
        end
        chk("walk_count", xfer_log.size(), 8);
        for (int i = 0; i < 8 && i < xfer_log.size(); i++) chk("walk_code", xfer_log[i], i);

        // Invalid pattern and err_count saturation
        hold(7'b1111111, 1, 1, 0, 5);
        step(7'd0, 1, 1, 0);
        chk("t3_err_pulse", err, 1);
        chk("t3_err_count", err_count, 1);
        step(7'd0, 1, 1, 0);
        chk("t3_err_drop", err, 0);
        chk("t3_no_code", code_valid, 0);
        for (int i = 0; i < 257; i++) begin
            hold(7'b1111111, 1, 1, 0, 5);
            step(7'd0, 1, 1, 0);
        end
        hold(7'd0, 1, 1, 0, 2);
        chk("t3_saturated", err_count, 255);
        step(7'd0, 1, 1, 1);
        step(7'd0, 1, 1, 0);
        chk("t3_cleared", err_count, 0);

        // Toggling never qualifies
        xfer_log.delete();
        for (int i = 0; i < 4; i++) begin
            hold(7'b1110111, 1, 1, 0, 3);
            hold(7'b1100010, 1, 1, 0, 3);
        end
        chk("t4_no_code", xfer_log.size(), 0);
        chk("t4_no_err", err_count, 0);

        // seg_en gap mid-count: only enabled samples count
        hold(7'b1110110, 1, 0, 0, 2);
        hold(7'b1110110, 0, 0, 0, 10);
        hold(7'b1110110, 1, 0, 0, 2);
        step(7'b1110110, 1, 0, 0);
        chk("t4_gap_pending", code_valid, 0);
        step(7'b1110110, 1, 0, 0);
        chk("t4_gap_valid", code_valid, 1);
        chk("t4_gap_code", code_out, 7);
        step(7'd0, 1, 1, 0);
        step(7'd0, 1, 0, 1);
        step(7'd0, 1, 0, 0);

        // Overrun and load-on-consume
        hold(pats[0], 1, 0, 0, 5);
        hold(7'd0, 1, 0, 0, 2);
        chk("t5_code0", code_out, 0);
        chk("t5_valid0", code_valid, 1);
        hold(pats[7], 1, 0, 0, 5);
        hold(7'd0, 1, 0, 0, 2);
        chk("t5_kept0", code_out, 0);
        chk("t5_ovr", ovr, 1);
        hold(pats[5], 1, 0, 0, 4);
        step(pats[5], 1, 1, 0);
        step(7'd0, 1, 0, 0);
        chk("t5_code5", code_out, 5);
        chk("t5_valid5", code_valid, 1);
        chk("t5_ovr_sticky", ovr, 1);

        // Asynchronous reset mid-count with a pending code
        step(7'b1011110, 1, 0, 0);
        step(7'b1011110, 1, 0, 0);
        step(7'b1011110, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", code_valid, 0);
        chk("t6_rst_code", code_out, 0);
        chk("t6_rst_ovr", ovr, 0);
        chk("t6_rst_err_count", err_count, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold(7'b1011110, 1, 0, 0, 4);
        chk("t6_requal_pending", code_valid, 0);
        step(7'b1011110, 1, 0, 0);
        chk("t6_requal_valid", code_valid, 1);
        chk("t6_requal_code", code_out, 3);

        hold(7'd0, 1, 1, 0, 3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
